// File: rtl/axi3_rd_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi3_rd_slave_if
//  Purpose  : AXI3 read-address and read-data channel bundle shared by the
//             read slave and whatever master drives it.
//  Ports    : AR channel  arid/araddr/arlen/arsize/arburst/arvalid -> slave,
//                         arready <- slave
//             R channel   rid/rdata/rresp/rlast/rvalid <- slave,
//                         rready -> slave
//  Modports : slave, master
//  Revision : 1.0 - initial release
// ============================================================================
interface axi3_rd_slave_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]   arid;
    logic [31:0]           araddr;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi3_rd_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi3_rd_slave
//  Purpose  : AXI3 read-only slave backed by an internal word array. One
//             burst outstanding at a time, first beat one cycle after the
//             AR handshake, back-to-back beats while rready is high.
//             Supported: 4-byte beats, FIXED and INCR bursts. Anything else
//             returns SLVERR with zero data for the full beat count.
//  Config   : define AXI3_RD_SLAVE_WRAP_EN to add WRAP bursts for
//             arlen in {1,3,7,15}; otherwise WRAP is answered with SLVERR.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low reset
//             bus        - axi3_rd_slave_if.slave (AR and R channels)
//             mem_we     - backdoor word write enable (preload)
//             mem_waddr  - backdoor word address
//             mem_wdata  - backdoor write data
//  Revision : 1.0 - initial release
// ============================================================================
module axi3_rd_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int ID_WIDTH   = 4
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    axi3_rd_slave_if.slave                    bus,
    input  wire logic                         mem_we,
    input  wire logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  wire logic [DATA_WIDTH-1:0]        mem_wdata
);

    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_BURST = 1'b1;

    localparam logic [1:0]    c_burst_fixed = 2'b00;
    localparam logic [1:0]    c_burst_incr  = 2'b01;
    localparam logic [1:0]    c_burst_wrap  = 2'b10;
    localparam logic [1:0]    c_resp_okay   = 2'b00;
    localparam logic [1:0]    c_resp_slverr = 2'b10;
    localparam logic [AW-1:0] c_idx_one     = {{(AW-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Array contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            r_mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Burst context
    // ------------------------------------------------------------------------
    logic [0:0]            r_state;
    logic                  r_arready;
    logic [ID_WIDTH-1:0]   r_id;
    logic [AW-1:0]         r_idx;
    logic [3:0]            r_len;
    logic [3:0]            r_cnt;
    logic [1:0]            r_burst;
    logic [2:0]            r_size;
    logic                  r_err;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_wrap_bad;
    logic                  w_err;
    logic [AW-1:0]         w_next_idx;
    logic [AW-1:0]         w_fetch_idx;
    logic [DATA_WIDTH-1:0] w_fetch_data;

    assign w_ar_hs = bus.arvalid && r_arready;
    assign w_r_hs  = r_rvalid && bus.rready;

`ifdef AXI3_RD_SLAVE_WRAP_EN
    // WRAP is only legal for 2/4/8/16-beat bursts.
    assign w_wrap_bad = (bus.arburst == c_burst_wrap) &&
                        !((bus.arlen == 4'd1) || (bus.arlen == 4'd3) ||
                          (bus.arlen == 4'd7) || (bus.arlen == 4'd15));
`else
    assign w_wrap_bad = (bus.arburst == c_burst_wrap);
`endif

    assign w_err = (bus.arsize != 3'b010) || (bus.arburst == 2'b11) || w_wrap_bad;

`ifdef AXI3_RD_SLAVE_WRAP_EN
    // With 4-byte beats and a power-of-two beat count, arlen is exactly the
    // mask of word-index bits that move inside the wrap window.
    logic [AW-1:0] w_wrap_mask;
    assign w_wrap_mask = AW'(r_len);
`endif

    always_comb begin
        w_next_idx = r_idx;
        case (r_burst)
            c_burst_incr:  w_next_idx = r_idx + c_idx_one;
`ifdef AXI3_RD_SLAVE_WRAP_EN
            c_burst_wrap:  w_next_idx = (r_idx & ~w_wrap_mask) |
                                        ((r_idx + c_idx_one) & w_wrap_mask);
`endif
            c_burst_fixed: w_next_idx = r_idx;
            default:       w_next_idx = r_idx;
        endcase
    end

    // The beat word is captured into r_rdata when it is presented. A backdoor
    // write landing on the same edge is forwarded so it is seen in that beat;
    // later writes leave the presented beat untouched.
    assign w_fetch_idx  = (r_state == S_IDLE) ? bus.araddr[AW+1:2] : w_next_idx;
    assign w_fetch_data = (mem_we && (mem_waddr == w_fetch_idx)) ? mem_wdata
                                                                 : r_mem[w_fetch_idx];

    // Address bits outside the array window and the byte offset are ignored;
    // arsize is kept for visibility only, its legality is folded into r_err.
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.araddr[31:AW+2], bus.araddr[1:0], r_size};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b0;
            r_id      <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_burst   <= '0;
            r_size    <= '0;
            r_err     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_state   <= S_BURST;
                        r_arready <= 1'b0;
                        r_id      <= bus.arid;
                        r_idx     <= bus.araddr[AW+1:2];
                        r_len     <= bus.arlen;
                        r_burst   <= bus.arburst;
                        r_size    <= bus.arsize;
                        r_err     <= w_err;
                        r_cnt     <= 4'd0;
                        r_rvalid  <= 1'b1;
                        r_rlast   <= (bus.arlen == 4'd0);
                        r_rresp   <= w_err ? c_resp_slverr : c_resp_okay;
                        r_rdata   <= w_err ? '0 : w_fetch_data;
                    end
                end
                S_BURST: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_state   <= S_IDLE;
                            r_arready <= 1'b1;
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                        end else begin
                            r_cnt   <= r_cnt + 4'd1;
                            r_idx   <= w_next_idx;
                            r_rlast <= ((r_cnt + 4'd1) == r_len);
                            r_rdata <= r_err ? '0 : w_fetch_data;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.arready = r_arready;
    assign bus.rid     = r_id;
    assign bus.rdata   = r_rdata;
    assign bus.rresp   = r_rresp;
    assign bus.rlast   = r_rlast;
    assign bus.rvalid  = r_rvalid;

endmodule
`default_nettype wire
